// File: rtl/bcd_convert_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// One accept cycle, eight shift cycles, then the result is held until acknowledged.
module bcd_convert_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [7:0]  BIN,
   input  logic        ACK,
   output logic        BUSY,
   output logic        VALID,
   output logic [11:0] BCD
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [7:0]  opnd;
   logic [11:0] acc;
   logic [11:0] adj;
   logic [11:0] acc_next;
   logic [11:0] bcd_q;

   // Digits >= 5 get +3 before the shift so they carry correctly into the next digit.
   always_comb begin
      adj = acc;
      for (int unsigned i = 0; i < 3; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
      acc_next = {adj[10:0], opnd[7]};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         cnt   <= '0;
         opnd  <= '0;
         acc   <= '0;
         bcd_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  opnd  <= BIN;
                  acc   <= '0;
                  cnt   <= 4'd8;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc  <= acc_next;
               opnd <= {opnd[6:0], 1'b0};
               cnt  <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  bcd_q <= acc_next;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (ACK) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign BUSY  = (state == S_SHIFT) || (state == S_DONE);
   assign VALID = (state == S_DONE);
   assign BCD   = bcd_q;

endmodule

// File: doc/bcd_convert_ctrl.md
BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits and result width at 12 bits (3 BCD digits).
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 START  input  1  conversion request; sampled only in IDLE.
REQ-005 BIN  input  8  unsigned binary operand; sampled on the same edge as an accepted START.
REQ-006 ACK  input  1  consumer acknowledge of a presented result; honoured only in DONE.
REQ-007 BUSY  output  1  high in SHIFT and DONE states.
REQ-008 VALID  output  1  high only in DONE; BCD is valid while VALID is high.
REQ-009 BCD  output  12  result: [11:8] hundreds, [7:4] tens, [3:0] units.

Function
REQ-010 The block SHALL implement a sequential shift-and-add-3 (double dabble) converter with FSM states IDLE, SHIFT and DONE.
REQ-011 IDLE: START=1 at an edge SHALL latch BIN into the shift register, clear the 12-bit digit accumulator, load the 4-bit bit counter with 8 and enter SHIFT.
REQ-012 IDLE: START=0 SHALL hold all state.
REQ-013 SHIFT: each edge SHALL first add 3 to every accumulator digit >= 5, then shift {accumulator, operand} left one bit, and decrement the counter.
REQ-014 SHIFT: the edge on which the counter goes from 1 to 0 SHALL perform the final shift, copy the final accumulator to BCD and enter DONE.
REQ-015 Latency: START accepted at edge k SHALL yield VALID=1 and the correct BCD after edge k+8 (exactly 8 SHIFT cycles).
REQ-016 BCD SHALL be a dedicated output register, updated only on entry to DONE; it SHALL hold the previous result throughout IDLE and SHIFT.
REQ-017 DONE: VALID SHALL stay high and BCD stable until ACK=1 is sampled; the block SHALL then return to IDLE on that edge.
REQ-018 ACK SHALL be ignored in IDLE and SHIFT.
REQ-019 START SHALL be ignored while BUSY=1, including in DONE when it coincides with ACK; a new conversion needs START in IDLE.
REQ-020 The minimum cycle-to-cycle throughput SHALL be 10 edges (1 accept, 8 shift, 1 ack), plus any consumer ACK delay.
REQ-021 All digits SHALL stay in 0..9; BCD[11:10] SHALL be 0 for every 8-bit operand (maximum 255 -> 0x255).
REQ-022 Changes on BIN after START is accepted SHALL NOT affect the conversion in progress.

Reset
REQ-023 RST=1 SHALL immediately, without waiting for CLK, force state=IDLE, BUSY=0, VALID=0, BCD=12'h000, counter=0, and clear the shift register and accumulator.
REQ-024 RST asserted mid-SHIFT or in DONE SHALL abort the conversion and discard the result; the first START after RST deasserts SHALL start a fresh conversion.
REQ-025 START sampled on the first edge after RST deassertion SHALL be accepted normally.

Verification
REQ-026 BIN=8'd0, START pulse -> after 8 shift edges, VALID=1, BCD=12'h000; ACK -> VALID=0, BUSY=0 next edge.
REQ-027 BIN=8'd255 -> BCD=12'h255; BIN=8'd99 -> BCD=12'h099; BIN=8'd100 -> BCD=12'h100; each with VALID exactly 8 edges after the accept edge.
REQ-028 START=1 with BIN=8'd37 during SHIFT of BIN=8'd200, and START together with ACK in DONE -> result 12'h200, no second conversion, block returns to IDLE.
REQ-029 ACK withheld for 20 cycles in DONE -> VALID and BCD=12'h128 (BIN=8'd128) stable for all 20 cycles; BIN toggled mid-SHIFT has no effect.
REQ-030 RST pulsed between clock edges at shift cycle 4 -> outputs clear immediately to 0; subsequent START with BIN=8'd42 -> BCD=12'h042 after 8 edges.
REQ-031 Exhaustive sweep BIN=0..255, back-to-back with ACK tied high -> every BCD matches the decimal reference and BCD[11:10]=0.
